ebi_arbiter: RTL and testbench
==============================

EBI_ARBITER -- requirements
Module: ebi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, EBI address width.
REQ-002 SHALL have parameter DATA_W, default 16, EBI data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, strobe length in clocks; legal range 1..15.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports m0_req / m1_req  in  1  access request, level, held until ack.
REQ-007 SHALL have ports m0_we / m1_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr / m1_addr  in  ADDR_W  access address.
REQ-009 SHALL have ports m0_wdata / m1_wdata  in  DATA_W  write data.
REQ-010 SHALL have ports m0_lock / m1_lock  in  1  keep grant across transactions (EBI_ARB_LOCK_EN only).
REQ-011 SHALL have ports m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports m0_rdata / m1_rdata  out  DATA_W  read data, valid with ack, held until next ack.
REQ-013 SHALL have ports ebi_cs, ebi_rden, ebi_wren  out  1  shared EBI strobes.
REQ-014 SHALL have ports ebi_addr / ebi_dout  out  ADDR_W / DATA_W  shared EBI address and write data.
REQ-015 SHALL have port ebi_din  in  DATA_W  EBI read data.

Function
REQ-016 SHALL implement FSM IDLE -> STROBE -> DONE -> IDLE.
REQ-017 IDLE: SHALL pick a winner from asserted reqs, register its we/addr/wdata, enter STROBE next cycle.
REQ-018 Arbitration SHALL be round-robin: on simultaneous reqs, the master not granted last wins; after reset m0 has priority.
REQ-019 STROBE: SHALL drive ebi_cs=1 and exactly one of ebi_rden/ebi_wren=1 for WAIT_CYCLES cycles, with addr/dout stable throughout.
REQ-020 Reads SHALL sample ebi_din on the last STROBE cycle into the winner's rdata register.
REQ-021 DONE: SHALL drive all strobes 0 and pulse the winner's ack for one cycle; the other ack SHALL stay 0.
REQ-022 Latency SHALL be req sampled in IDLE at cycle 0, strobes in cycles 1..WAIT_CYCLES, ack in cycle WAIT_CYCLES+1.
REQ-023 Back-to-back transactions SHALL have at least one strobe-free cycle (DONE) between them.
REQ-024 A req deasserted before ack SHALL NOT abort an access already in STROBE; the access completes and acks.
REQ-025 The strobe counter SHALL be 4 bits, reload to WAIT_CYCLES-1, and never wrap.
REQ-026 ebi_addr/ebi_dout SHALL hold their last value outside STROBE.

Reset
REQ-027 On rst_n=0 all strobes, acks, rdata, ebi_addr, ebi_dout, the counter and the RR pointer SHALL go to 0 immediately; FSM to IDLE.
REQ-028 Reset during STROBE SHALL drop strobes asynchronously and SHALL NOT produce an ack after release.

Configuration
REQ-029 Macro EBI_ARB_LOCK_EN: when defined, a winner holding mN_lock=1 at its DONE SHALL be regranted in the next IDLE over the other master; lock is ignored while req=0.
REQ-030 Without EBI_ARB_LOCK_EN, lock ports SHALL be present but unused, and arbitration SHALL be pure round-robin.

Structure
REQ-031 Package ebi_arb_pkg SHALL hold the FSM state encoding (IDLE=0, STROBE=1, DONE=2) and the master index constants.
REQ-032 Winner selection SHALL live in sub-module ebi_arb_rr (2 reqs, last-grant pointer, lock inputs -> one-hot grant).

Verification
REQ-033 m0 write addr 0x1234 data 0x5678, WAIT_CYCLES=2 -> ebi_wren high 2 cycles with addr 0x1234 and dout 0x5678; m0_ack at cycle 3.
REQ-034 m1 read addr 0x0011, ebi_din=0xABAB -> ebi_rden high 2 cycles; m1_ack with m1_rdata=0xABAB; m0_ack stays 0.
REQ-035 m0 and m1 req in the same cycle after reset -> m0 served first, m1 next; repeat -> order m0, m1 alternating.
REQ-036 With EBI_ARB_LOCK_EN, m0_lock=1 for 3 writes while m1_req is held -> three m0 accesses complete before m1 is granted.
REQ-037 rst_n asserted during a STROBE cycle -> strobes drop in the same cycle; no ack after release; next access starts from m0 priority.

Source files
------------

// File: rtl/ebi_arb_pkg.sv
// Shared types and constants for the two-master EBI arbiter:
// FSM state encoding and master index constants.
package ebi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int unsigned N_MASTERS = 2;
    localparam int unsigned M0        = 0;
    localparam int unsigned M1        = 1;

    // Counter preload so that the strobe lasts exactly wait_cycles clocks.
    function automatic logic [3:0] strobe_reload(input int unsigned wait_cycles);
        return 4'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/ebi_arbiter_if.sv
// Bundle of the two master request/response ports and the shared EBI pins.
// slave = arbiter side, master = request/pin-driver side.
interface ebi_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_lock,  m1_lock;
    logic              m0_ack,   m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              ebi_cs;
    logic              ebi_rden;
    logic              ebi_wren;
    logic [ADDR_W-1:0] ebi_addr;
    logic [DATA_W-1:0] ebi_dout;
    logic [DATA_W-1:0] ebi_din;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, ebi_din,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
               ebi_cs, ebi_rden, ebi_wren, ebi_addr, ebi_dout
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, ebi_din,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata,
               ebi_cs, ebi_rden, ebi_wren, ebi_addr, ebi_dout
    );
endinterface

// File: rtl/ebi_arb_rr.sv
// Two-way winner selection: a held lock wins first, otherwise round-robin
// between simultaneous requests using the priority pointer.
module ebi_arb_rr
    import ebi_arb_pkg::*;
(
    input  logic [N_MASTERS-1:0] req,
    input  logic                 rr_ptr,   // 0: m0 has priority, 1: m1 has priority
    input  logic [N_MASTERS-1:0] lock,     // one-hot lock claim from the previous owner
    output logic [N_MASTERS-1:0] grant
);
    logic [N_MASTERS-1:0] locked;

    always_comb begin
        grant  = '0;
        locked = req & lock;
        if (locked != '0) begin
            grant = locked;
        end else if (req == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end
endmodule

// File: rtl/ebi_arbiter.sv
// Two-master external bus interface arbiter: IDLE -> STROBE -> DONE.
// Optional feature: define EBI_ARB_LOCK_EN to let a locked owner keep the grant.
module ebi_arbiter
    import ebi_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ebi_arbiter_if.slave  bus
);
    localparam logic [3:0] CNT_RELOAD = strobe_reload(WAIT_CYCLES);

    state_t               state_reg, state_next;
    logic [3:0]           cnt_reg;
    logic                 win_reg;      // 0 = m0 owns the access, 1 = m1
    logic                 we_reg;
    logic                 rr_ptr_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    dout_reg;
    logic [DATA_W-1:0]    rdata_reg [N_MASTERS];

    logic [N_MASTERS-1:0] req_vec;
    logic [N_MASTERS-1:0] lock_claim;
    logic [N_MASTERS-1:0] grant;
    logic [N_MASTERS-1:0] win_onehot;
    logic [N_MASTERS-1:0] ack_vec;
    logic                 last_strobe;

    assign req_vec     = {bus.m1_req, bus.m0_req};
    assign win_onehot  = {win_reg, ~win_reg};
    assign last_strobe = (state_reg == ST_STROBE) && (cnt_reg == 4'd0);

`ifdef EBI_ARB_LOCK_EN
    logic [N_MASTERS-1:0] lock_hold_reg;

    // Captured at DONE from the finishing owner's lock; applied at the next IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_hold_reg <= '0;
        end else if (state_reg == ST_DONE) begin
            lock_hold_reg <= win_onehot & {bus.m1_lock, bus.m0_lock};
        end
    end

    assign lock_claim = lock_hold_reg;
`else
    assign lock_claim = '0;
`endif

    ebi_arb_rr u_rr (
        .req    (req_vec),
        .rr_ptr (rr_ptr_reg),
        .lock   (lock_claim),
        .grant  (grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req_vec != '0) state_next = ST_STROBE;
            ST_STROBE: if (cnt_reg == 4'd0) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic: strobes and acks decode straight from the state so reset drops them at once
    always_comb begin
        bus.ebi_cs   = 1'b0;
        bus.ebi_rden = 1'b0;
        bus.ebi_wren = 1'b0;
        ack_vec      = '0;
        case (state_reg)
            ST_STROBE: begin
                bus.ebi_cs   = 1'b1;
                bus.ebi_wren = we_reg;
                bus.ebi_rden = ~we_reg;
            end
            ST_DONE:   ack_vec = win_onehot;
            default:   ;
        endcase
    end

    // Access capture, strobe counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= 4'd0;
            win_reg    <= 1'b0;
            we_reg     <= 1'b0;
            rr_ptr_reg <= 1'b0;
            addr_reg   <= '0;
            dout_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_vec != '0) begin
                        win_reg    <= grant[M1];
                        we_reg     <= grant[M1] ? bus.m1_we    : bus.m0_we;
                        addr_reg   <= grant[M1] ? bus.m1_addr  : bus.m0_addr;
                        dout_reg   <= grant[M1] ? bus.m1_wdata : bus.m0_wdata;
                        cnt_reg    <= CNT_RELOAD;
                        rr_ptr_reg <= ~grant[M1];
                    end
                end
                ST_STROBE: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-master read data, loaded on the final strobe cycle of that master's read
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_rdata
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_reg[gi] <= '0;
            end else if (last_strobe && !we_reg && win_onehot[gi]) begin
                rdata_reg[gi] <= bus.ebi_din;
            end
        end
    end

    assign bus.ebi_addr = addr_reg;
    assign bus.ebi_dout = dout_reg;
    assign bus.m0_ack   = ack_vec[M0];
    assign bus.m1_ack   = ack_vec[M1];
    assign bus.m0_rdata = rdata_reg[M0];
    assign bus.m1_rdata = rdata_reg[M1];

endmodule

// File: tb/tb_ebi_arbiter.sv
// Directed-vector bench for ebi_arbiter (WAIT_CYCLES=2); the lock sequence
// expects regrant order when EBI_ARB_LOCK_EN is defined, plain round-robin otherwise.
module tb_ebi_arbiter;
    import ebi_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int W  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ebi_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ebi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_rdata [2];

    typedef struct {
        logic          m0_req;
        logic          m0_we;
        logic [AW-1:0] m0_addr;
        logic [DW-1:0] m0_wdata;
        logic          m1_req;
        logic          m1_we;
        logic [AW-1:0] m1_addr;
        logic [DW-1:0] m1_wdata;
        logic [DW-1:0] din;
        int            win;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic drive_idle();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_lock = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_lock = 0;
        bus.ebi_din = '0;
    endtask

    task automatic apply(input vec_t v);
        bus.m0_req = v.m0_req; bus.m0_we = v.m0_we; bus.m0_addr = v.m0_addr; bus.m0_wdata = v.m0_wdata;
        bus.m1_req = v.m1_req; bus.m1_we = v.m1_we; bus.m1_addr = v.m1_addr; bus.m1_wdata = v.m1_wdata;
        bus.ebi_din = v.din;
    endtask

    // Called with the DUT in IDLE and requests already driven.
    task automatic run_txn(input int win, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] din);
        logic [1:0] exp_ack;
        exp_ack = (win == 1) ? 2'b10 : 2'b01;
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            chk("strobe_cs",   bus.ebi_cs, 1'b1);
            chk("strobe_wren", bus.ebi_wren, we);
            chk("strobe_rden", bus.ebi_rden, !we);
            chk("strobe_addr", bus.ebi_addr, addr);
            if (we) chk("strobe_dout", bus.ebi_dout, wdata);
            chk("strobe_ack",  {bus.m1_ack, bus.m0_ack}, 2'b00);
        end
        @(posedge clk); #1;
        if (!we) exp_rdata[win] = din;
        chk("done_cs",     bus.ebi_cs, 1'b0);
        chk("done_rw",     {bus.ebi_wren, bus.ebi_rden}, 2'b00);
        chk("done_ack",    {bus.m1_ack, bus.m0_ack}, exp_ack);
        chk("done_rdata0", bus.m0_rdata, exp_rdata[0]);
        chk("done_rdata1", bus.m1_rdata, exp_rdata[1]);
        $display("txn m%0d %s addr=%h wdata=%h din=%h ack=%b rdata0=%h rdata1=%h",
                 win, we ? "WR" : "RD", addr, wdata, din, {bus.m1_ack, bus.m0_ack},
                 bus.m0_rdata, bus.m1_rdata);
        if (win == 1) bus.m1_req = 0; else bus.m0_req = 0;
        @(posedge clk); #1;
        chk("gap_cs",  bus.ebi_cs, 1'b0);
        chk("gap_ack", {bus.m1_ack, bus.m0_ack}, 2'b00);
    endtask

    int lock_exp [4];
    int m0_done, m1_done, w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;

    initial begin
        //        m0: req we  addr      wdata     m1: req we  addr      wdata     din       win
        vecs[0] = '{1, 1, 16'h1234, 16'h5678, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[1] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0011, 16'h0000, 16'hABAB, 1};
        vecs[2] = '{1, 0, 16'h00A0, 16'h0000, 1, 1, 16'h00B0, 16'hBEEF, 16'h1111, 0};
        vecs[3] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h00B0, 16'hBEEF, 16'h0000, 1};
        vecs[4] = '{1, 1, 16'h0C0C, 16'h3333, 1, 0, 16'h0D0D, 16'h0000, 16'h2222, 0};
        vecs[5] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0D0D, 16'h0000, 16'h2222, 1};
        vecs[6] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'hFFFF, 16'h0001, 16'h0000, 1};
        vecs[7] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, 16'h0000, 16'h4444, 1};
        vecs[8] = '{1, 1, 16'h0003, 16'hAAAA, 1, 1, 16'h0004, 16'h5555, 16'h0000, 0};
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;

        // Reset state
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("rst_cs",     bus.ebi_cs, 1'b0);
        chk("rst_rw",     {bus.ebi_wren, bus.ebi_rden}, 2'b00);
        chk("rst_ack",    {bus.m1_ack, bus.m0_ack}, 2'b00);
        chk("rst_addr",   bus.ebi_addr, 16'h0000);
        chk("rst_dout",   bus.ebi_dout, 16'h0000);
        chk("rst_rdata0", bus.m0_rdata, 16'h0000);
        chk("rst_rdata1", bus.m1_rdata, 16'h0000);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven transactions
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i]);
            if (vecs[i].win == 1)
                run_txn(1, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_wdata, vecs[i].din);
            else
                run_txn(0, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata, vecs[i].din);
        end

        // Reset during STROBE: pointer now favours m1, so m1 wins this access
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'h0100; bus.m0_wdata = 16'h0001;
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 16'h0200; bus.m1_wdata = 16'h0002;
        @(posedge clk); #1;
        chk("pre_rst_cs",   bus.ebi_cs, 1'b1);
        chk("pre_rst_addr", bus.ebi_addr, 16'h0200);
        rst_n = 1'b0;
        #1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        chk("mid_rst_cs",     bus.ebi_cs, 1'b0);
        chk("mid_rst_rw",     {bus.ebi_wren, bus.ebi_rden}, 2'b00);
        chk("mid_rst_addr",   bus.ebi_addr, 16'h0000);
        chk("mid_rst_dout",   bus.ebi_dout, 16'h0000);
        chk("mid_rst_rdata0", bus.m0_rdata, 16'h0000);
        bus.m0_req = 0; bus.m1_req = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_rst_ack", {bus.m1_ack, bus.m0_ack}, 2'b00);
            chk("post_rst_cs",  bus.ebi_cs, 1'b0);
        end
        $display("txn reset-during-strobe handled");
        bus.m0_req = 1; bus.m1_req = 1;
        run_txn(0, 1'b1, 16'h0100, 16'h0001, 16'h0000);
        run_txn(1, 1'b1, 16'h0200, 16'h0002, 16'h0000);

        // Request withdrawn during STROBE: access still completes
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 16'h0300; bus.ebi_din = 16'h7777;
        @(posedge clk); #1;
        chk("wd_cs1", bus.ebi_cs, 1'b1);
        chk("wd_rden1", bus.ebi_rden, 1'b1);
        bus.m0_req = 0;
        @(posedge clk); #1;
        chk("wd_cs2", bus.ebi_cs, 1'b1);
        @(posedge clk); #1;
        exp_rdata[0] = 16'h7777;
        chk("wd_ack",   {bus.m1_ack, bus.m0_ack}, 2'b01);
        chk("wd_rdata", bus.m0_rdata, 16'h7777);
        $display("txn m0 RD addr=0300 withdrawn-req ack=%b rdata0=%h", bus.m0_ack, bus.m0_rdata);
        @(posedge clk); #1;

        // m1 access returns priority to m0 before the lock sequence
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 16'h0400; bus.ebi_din = 16'h8888;
        run_txn(1, 1'b0, 16'h0400, 16'h0000, 16'h8888);

`ifdef EBI_ARB_LOCK_EN
        lock_exp = '{0, 0, 0, 1};
`else
        lock_exp = '{0, 1, 0, 0};
`endif
        m0_done = 0;
        m1_done = 0;
        bus.m1_we = 1; bus.m1_addr = 16'h0500; bus.m1_wdata = 16'h0B0B;
        bus.m0_we = 1;
        for (int j = 0; j < 4; j++) begin
            bus.m0_req    = (m0_done < 3);
            bus.m0_lock   = (m0_done < 2);
            bus.m0_addr   = 16'(16'h0600 + m0_done);
            bus.m0_wdata  = 16'(16'h1000 + m0_done);
            bus.m1_req    = (m1_done == 0);
            w  = lock_exp[j];
            ea = (w == 1) ? 16'h0500 : 16'(16'h0600 + m0_done);
            ed = (w == 1) ? 16'h0B0B : 16'(16'h1000 + m0_done);
            run_txn(w, 1'b1, ea, ed, 16'h0000);
            if (w == 1) m1_done++; else m0_done++;
        end
        bus.m0_lock = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
